led_bar_sequencer: RTL and testbench

LED_BAR_SEQUENCER -- requirements
Module: led_bar_sequencer

---
 rtl/led_bar_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_led_bar_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/led_bar_sequencer.sv
// ---------------------------------------------------------------------------
// led_bar_sequencer
//
// Drives a bar of WIDTH LEDs with one of four animated patterns. A free
// running prescaler produces one pattern step ("tick") every
// 2^PRESCALE_BITS clocks while running. The pattern may be paused and
// resumed, aborted, or restarted with a new pattern at any time.
//
// Ports
//   clock   : sole clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : one-clock pulse, begins or restarts a sequence (samples mode)
//   stop    : one-clock pulse, aborts to idle (ignored when idle)
//   pause   : one-clock pulse, toggles run/hold (ignored when idle)
//   mode    : pattern select 0=FILL 1=DRAIN 2=BOUNCE 3=BLINK
//   io_led  : registered LED bar drive
//   busy    : high while running or holding
//   done    : one-clock pulse after each completed pattern cycle
//   cycles  : completed-cycle count since last start, wraps 255->0
//
// Handshake: start/stop/pause are plain single-clock strobes with no
// ready; each is acted on at the rising edge where it is sampled high,
// with priority stop > start > pause.
// ---------------------------------------------------------------------------
module led_bar_sequencer #(
   parameter int WIDTH         = 24,
   parameter int PRESCALE_BITS = 23
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] io_led,
   output logic             busy,
   output logic             done,
   output logic [7:0]       cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [1:0] M_FILL   = 2'd0;
   localparam logic [1:0] M_DRAIN  = 2'd1;
   localparam logic [1:0] M_BOUNCE = 2'd2;
   localparam logic [1:0] M_BLINK  = 2'd3;

   localparam logic [WIDTH-1:0]         LED_ONES  = '1;
   localparam logic [WIDTH-1:0]         LED_ZERO  = '0;
   localparam logic [WIDTH-1:0]         LED_BIT0  = WIDTH'(1);
   localparam logic [PRESCALE_BITS-1:0] PRESC_MAX = '1;

   // dir: 0 = moving left (towards MSB), 1 = moving right (towards bit 0)
   state_t                   state_q, state_d;
   logic [1:0]               mode_q, mode_d;
   logic                     dir_q, dir_d;
   logic [PRESCALE_BITS-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]         led_q, led_d;
   logic                     done_q, done_d;
   logic [7:0]               cycles_q, cycles_d;

   logic                     tick;
   logic [WIDTH-1:0]         pat_led;
   logic                     pat_dir;
   logic                     pat_done;
   logic [WIDTH-1:0]         init_led;

   assign tick = (state_q == S_RUN) && (presc_q == PRESC_MAX);

   // Next pattern value assuming a tick happens this clock.
   always_comb begin
      pat_led  = led_q;
      pat_dir  = dir_q;
      pat_done = 1'b0;
      case (mode_q)
         M_FILL: begin
            if (led_q == LED_ONES) begin
               pat_led  = LED_ZERO;
               pat_done = 1'b1;
            end else begin
               pat_led = (led_q << 1) | LED_BIT0;
            end
         end
         M_DRAIN: begin
            if (led_q == LED_ZERO) begin
               pat_led  = LED_ONES;
               pat_done = 1'b1;
            end else begin
               pat_led = led_q >> 1;
            end
         end
         M_BOUNCE: begin
            // Direction flips on the tick that lands on an end bit, so the
            // following tick already moves back the other way.
            if (!dir_q) begin
               pat_led = led_q << 1;
               if (pat_led[WIDTH-1]) pat_dir = 1'b1;
            end else begin
               pat_led = led_q >> 1;
               if (pat_led[0]) begin
                  pat_dir  = 1'b0;
                  pat_done = 1'b1;
               end
            end
         end
         default: begin // M_BLINK
            if (led_q == LED_ZERO) begin
               pat_led = LED_ONES;
            end else begin
               pat_led  = LED_ZERO;
               pat_done = 1'b1;
            end
         end
      endcase
   end

   // Pattern loaded when a start is accepted.
   always_comb begin
      init_led = LED_ZERO;
      case (mode)
         M_DRAIN:  init_led = LED_ONES;
         M_BOUNCE: init_led = LED_BIT0;
         default:  init_led = LED_ZERO;
      endcase
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      dir_d    = dir_q;
      presc_d  = presc_q;
      led_d    = led_q;
      done_d   = 1'b0;
      cycles_d = cycles_q;

      if (stop && (state_q != S_IDLE)) begin
         // Wins over a coincident tick: no done, no count.
         state_d = S_IDLE;
         presc_d = '0;
         led_d   = LED_ZERO;
      end else if (start) begin
         state_d  = S_RUN;
         mode_d   = mode;
         presc_d  = '0;
         cycles_d = 8'd0;
         led_d    = init_led;
         dir_d    = 1'b0;
      end else begin
         // A pause sampled while running still counts this clock as a run
         // clock; hold only takes effect from the next edge.
         if (state_q == S_RUN) begin
            presc_d = presc_q + 1'b1;
            if (tick) begin
               led_d = pat_led;
               dir_d = pat_dir;
               if (pat_done) begin
                  done_d   = 1'b1;
                  cycles_d = cycles_q + 8'd1;
               end
            end
         end
         if (pause) begin
            case (state_q)
               S_RUN:   state_d = S_HOLD;
               S_HOLD:  state_d = S_RUN;
               default: state_d = state_q;
            endcase
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mode_q   <= 2'd0;
         dir_q    <= 1'b0;
         presc_q  <= '0;
         led_q    <= '0;
         done_q   <= 1'b0;
         cycles_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         dir_q    <= dir_d;
         presc_q  <= presc_d;
         led_q    <= led_d;
         done_q   <= done_d;
         cycles_q <= cycles_d;
      end
   end

   assign io_led = led_q;
   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign cycles = cycles_q;

endmodule

// File: tb/tb_led_bar_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_bar_sequencer
//
// Directed bench for led_bar_sequencer with WIDTH=4, PRESCALE_BITS=2 (one
// tick per 4 clocks). A table of {inputs, clocks to run, expected outputs}
// records drives the bulk of the scenarios; the asynchronous reset with the
// clock stopped is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_led_bar_sequencer;

   localparam int W  = 4;
   localparam int PB = 2;

   logic         clock;
   logic         clk_en;
   logic         rst_n;
   logic         start;
   logic         stop;
   logic         pause;
   logic [1:0]   mode;
   logic [W-1:0] io_led;
   logic         busy;
   logic         done;
   logic [7:0]   cycles;

   int errors = 0;
   int checks = 0;

   led_bar_sequencer #(.WIDTH(W), .PRESCALE_BITS(PB)) dut (
      .clock  (clock),
      .rst_n  (rst_n),
      .start  (start),
      .stop   (stop),
      .pause  (pause),
      .mode   (mode),
      .io_led (io_led),
      .busy   (busy),
      .done   (done),
      .cycles (cycles)
   );

   // ---------------- clock (gateable so reset can be hit with it stopped)
   initial begin
      clock = 1'b0;
      forever begin
         #5;
         if (clk_en) clock = ~clock;
      end
   end

   // ---------------- vector table
   typedef struct {
      string      name;
      logic       st;
      logic       sp;
      logic       pa;
      logic [1:0] md;
      int         n;      // clocks to run; inputs applied on the first only
      logic [3:0] led;
      logic       bsy;
      logic       dn;
      logic [7:0] cyc;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(string name, logic st, logic sp, logic pa,
                               logic [1:0] md, int n, logic [3:0] led,
                               logic bsy, logic dn, logic [7:0] cyc);
      vec_t v;
      v.name = name; v.st = st; v.sp = sp; v.pa = pa; v.md = md; v.n = n;
      v.led = led; v.bsy = bsy; v.dn = dn; v.cyc = cyc;
      vecs.push_back(v);
   endfunction

   // ---------------- driver / checker tasks
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (row %0d): got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic run_vec(int idx, vec_t v);
      start = v.st;
      stop  = v.sp;
      pause = v.pa;
      // Non-start rows drive a changing mode; it must be ignored.
      mode  = v.st ? v.md : 2'(idx);
      step();
      start = 1'b0;
      stop  = 1'b0;
      pause = 1'b0;
      repeat (v.n - 1) step();
      chk({v.name, ".io_led"}, idx, 32'(io_led), 32'(v.led));
      chk({v.name, ".busy"},   idx, 32'(busy),   32'(v.bsy));
      chk({v.name, ".done"},   idx, 32'(done),   32'(v.dn));
      chk({v.name, ".cycles"}, idx, 32'(cycles), 32'(v.cyc));
   endtask

   initial begin
      clk_en = 1'b1;
      rst_n  = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      pause  = 1'b0;
      mode   = 2'd0;

      //   name        st sp pa md  n  led    bsy dn  cyc
      // FILL: updates 4,8,12,16,20 clocks after start, done after the 20th
      add("fill",     1, 0, 0, 0, 1, 4'h0, 1, 0, 8'd0);
      add("fill",     0, 0, 0, 0, 4, 4'h1, 1, 0, 8'd0);
      add("fill",     0, 0, 0, 0, 4, 4'h3, 1, 0, 8'd0);
      add("fill",     0, 0, 0, 0, 4, 4'h7, 1, 0, 8'd0);
      add("fill",     0, 0, 0, 0, 4, 4'hF, 1, 0, 8'd0);
      add("fill",     0, 0, 0, 0, 4, 4'h0, 1, 1, 8'd1);
      add("fill",     0, 0, 0, 0, 1, 4'h0, 1, 0, 8'd1);
      add("fill",     0, 0, 0, 0, 3, 4'h1, 1, 0, 8'd1);
      // stop aborts, cycles retained; pause/stop in idle ignored
      add("stop",     0, 1, 0, 0, 1, 4'h0, 0, 0, 8'd1);
      add("idle_pa",  0, 0, 1, 0, 1, 4'h0, 0, 0, 8'd1);
      add("idle_sp",  0, 1, 0, 0, 1, 4'h0, 0, 0, 8'd1);
      // BOUNCE: 0001 load then 0010 0100 1000 0100 0010 0001(done)
      add("bounce",   1, 0, 0, 2, 1, 4'h1, 1, 0, 8'd0);
      add("bounce",   0, 0, 0, 0, 4, 4'h2, 1, 0, 8'd0);
      add("bounce",   0, 0, 0, 0, 4, 4'h4, 1, 0, 8'd0);
      add("bounce",   0, 0, 0, 0, 4, 4'h8, 1, 0, 8'd0);
      add("bounce",   0, 0, 0, 0, 4, 4'h4, 1, 0, 8'd0);
      add("bounce",   0, 0, 0, 0, 4, 4'h2, 1, 0, 8'd0);
      add("bounce",   0, 0, 0, 0, 4, 4'h1, 1, 1, 8'd1);
      add("bounce",   0, 0, 0, 0, 1, 4'h1, 1, 0, 8'd1);
      add("bounce",   0, 0, 0, 0, 3, 4'h2, 1, 0, 8'd1);
      // Restart into FILL, then restart into BLINK mid-prescale
      add("restart",  1, 0, 0, 0, 1, 4'h0, 1, 0, 8'd0);
      add("restart",  0, 0, 0, 0, 4, 4'h1, 1, 0, 8'd0);
      add("restart",  0, 0, 0, 0, 4, 4'h3, 1, 0, 8'd0);
      add("restart",  0, 0, 0, 0, 2, 4'h3, 1, 0, 8'd0);
      add("blink",    1, 0, 0, 3, 1, 4'h0, 1, 0, 8'd0);
      add("blink",    0, 0, 0, 0, 3, 4'h0, 1, 0, 8'd0);
      add("blink",    0, 0, 0, 0, 1, 4'hF, 1, 0, 8'd0);
      add("blink",    0, 0, 0, 0, 4, 4'h0, 1, 1, 8'd1);
      add("blink",    0, 0, 0, 0, 4, 4'hF, 1, 0, 8'd1);
      // start+stop together while running: stop wins
      add("prio_ss",  1, 1, 0, 1, 1, 4'h0, 0, 0, 8'd1);
      // start+pause together in idle: start wins, runs (not held)
      add("prio_sp",  1, 0, 1, 3, 1, 4'h0, 1, 0, 8'd0);
      add("prio_sp",  0, 0, 0, 0, 4, 4'hF, 1, 0, 8'd0);
      // DRAIN with pause 2 clocks after the 1111->0111 tick, held 20 clocks
      add("drain",    1, 0, 0, 1, 1, 4'hF, 1, 0, 8'd0);
      add("drain",    0, 0, 0, 0, 4, 4'h7, 1, 0, 8'd0);
      add("drain",    0, 0, 0, 0, 1, 4'h7, 1, 0, 8'd0);
      add("hold",     0, 0, 1, 0, 1, 4'h7, 1, 0, 8'd0);
      add("hold",     0, 0, 0, 0, 10, 4'h7, 1, 0, 8'd0);
      add("hold",     0, 0, 0, 0, 9, 4'h7, 1, 0, 8'd0);
      add("resume",   0, 0, 1, 0, 1, 4'h7, 1, 0, 8'd0);
      add("resume",   0, 0, 0, 0, 1, 4'h7, 1, 0, 8'd0);
      add("resume",   0, 0, 0, 0, 1, 4'h3, 1, 0, 8'd0);
      // stop on the completing DRAIN tick: no done, no count
      add("stop_tick", 0, 0, 0, 0, 8, 4'h0, 1, 0, 8'd0);
      add("stop_tick", 0, 0, 0, 0, 3, 4'h0, 1, 0, 8'd0);
      add("stop_tick", 0, 1, 0, 0, 1, 4'h0, 0, 0, 8'd0);
      add("stop_tick", 0, 0, 0, 0, 1, 4'h0, 0, 0, 8'd0);

      // ---------------- reset values
      #12;
      chk("rst.io_led", -1, 32'(io_led), 32'h0);
      chk("rst.busy",   -1, 32'(busy),   32'h0);
      chk("rst.done",   -1, 32'(done),   32'h0);
      chk("rst.cycles", -1, 32'(cycles), 32'h0);
      @(negedge clock);
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // ---------------- async reset mid-RUN with the clock stopped
      start = 1'b1;
      mode  = 2'd3;
      step();
      start = 1'b0;
      repeat (12) step();
      chk("pre_rst.io_led", -2, 32'(io_led), 32'hF);
      chk("pre_rst.cycles", -2, 32'(cycles), 32'd1);
      clk_en = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst.io_led", -2, 32'(io_led), 32'h0);
      chk("async_rst.busy",   -2, 32'(busy),   32'h0);
      chk("async_rst.done",   -2, 32'(done),   32'h0);
      chk("async_rst.cycles", -2, 32'(cycles), 32'h0);
      #2;
      rst_n  = 1'b1;
      #2;
      clk_en = 1'b1;
      // stays idle after reset release until a start
      repeat (6) step();
      chk("post_rst.io_led", -3, 32'(io_led), 32'h0);
      chk("post_rst.busy",   -3, 32'(busy),   32'h0);
      chk("post_rst.done",   -3, 32'(done),   32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
